pixel_raster_writer: RTL and testbench

PIXEL_RASTER_WRITER -- requirements
Module: pixel_raster_writer

---
 rtl/pixel_raster_writer.sv | 175 +++++++++++++++++
 tb/tb_pixel_raster_writer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_raster_writer.sv
// Converts an MCU-ordered pixel stream into raster-addressed frame-buffer writes,
// cropping pixels that fall outside the image and signalling frame completion.
module pixel_raster_writer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode_420,
    input  logic [15:0]       img_width,
    input  logic [15:0]       img_height,
    input  logic [7:0]        r_in,
    input  logic [7:0]        g_in,
    input  logic [7:0]        b_in,
    input  logic              pixel_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic              frame_done,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;

    logic        s16_q;
    logic [15:0] width_q, height_q, cols_q, rows_q;
    logic [3:0]  col_q, row_q;
    logic [15:0] mcu_x_q, mcu_y_q;

    logic        p1_wr, p1_last;
    logic [15:0] p1_x, p1_y;
    logic [23:0] p1_data;

    logic [16:0] w_round, h_round;
    logic [15:0] cols_in, rows_in;
    logic        zero_geom;

    logic        s16_e;
    logic [15:0] width_e, height_e, cols_e, rows_e;
    logic [3:0]  col_e, row_e, smax;
    logic [15:0] mcu_x_e, mcu_y_e, x_c, y_c;
    logic        accept, keep, last;

    always_comb begin
        w_round   = {1'b0, img_width}  + (mode_420 ? 17'd15 : 17'd7);
        h_round   = {1'b0, img_height} + (mode_420 ? 17'd15 : 17'd7);
        cols_in   = mode_420 ? 16'(w_round >> 4) : 16'(w_round >> 3);
        rows_in   = mode_420 ? 16'(h_round >> 4) : 16'(h_round >> 3);
        zero_geom = (img_width == '0) || (img_height == '0);
    end

    // A start in the same cycle as a pixel makes that pixel (0,0) of the new frame,
    // so the "effective" geometry and counters are muxed from the inputs on start.
    always_comb begin
        s16_e    = start ? mode_420   : s16_q;
        width_e  = start ? img_width  : width_q;
        height_e = start ? img_height : height_q;
        cols_e   = start ? cols_in    : cols_q;
        rows_e   = start ? rows_in    : rows_q;
        col_e    = start ? '0 : col_q;
        row_e    = start ? '0 : row_q;
        mcu_x_e  = start ? '0 : mcu_x_q;
        mcu_y_e  = start ? '0 : mcu_y_q;

        smax   = s16_e ? 4'd15 : 4'd7;
        x_c    = (s16_e ? (mcu_x_e << 4) : (mcu_x_e << 3)) + {12'd0, col_e};
        y_c    = (s16_e ? (mcu_y_e << 4) : (mcu_y_e << 3)) + {12'd0, row_e};
        keep   = (x_c < width_e) && (y_c < height_e);
        last   = (col_e == smax) && (row_e == smax) &&
                 (mcu_x_e == cols_e - 16'd1) && (mcu_y_e == rows_e - 16'd1);
        accept = pixel_valid && (start ? !zero_geom : (state == RUN));
    end

    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = zero_geom ? IDLE : RUN;
        end else begin
            case (state)
                RUN:     if (accept && last) state_nx = DRAIN;
                DRAIN:   if (frame_done)     state_nx = IDLE;
                default: state_nx = state;
            endcase
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            s16_q      <= 1'b0;
            width_q    <= '0;
            height_q   <= '0;
            cols_q     <= '0;
            rows_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            mcu_x_q    <= '0;
            mcu_y_q    <= '0;
            p1_wr      <= 1'b0;
            p1_last    <= 1'b0;
            p1_x       <= '0;
            p1_y       <= '0;
            p1_data    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state <= state_nx;

            if (start) begin
                s16_q    <= mode_420;
                width_q  <= img_width;
                height_q <= img_height;
                cols_q   <= cols_in;
                rows_q   <= rows_in;
            end

            if (accept) begin
                if (col_e == smax) begin
                    col_q <= '0;
                    if (row_e == smax) begin
                        row_q <= '0;
                        if (mcu_x_e == cols_e - 16'd1) begin
                            mcu_x_q <= '0;
                            mcu_y_q <= mcu_y_e + 16'd1;
                        end else begin
                            mcu_x_q <= mcu_x_e + 16'd1;
                            mcu_y_q <= mcu_y_e;
                        end
                    end else begin
                        row_q   <= row_e + 4'd1;
                        mcu_x_q <= mcu_x_e;
                        mcu_y_q <= mcu_y_e;
                    end
                end else begin
                    col_q   <= col_e + 4'd1;
                    row_q   <= row_e;
                    mcu_x_q <= mcu_x_e;
                    mcu_y_q <= mcu_y_e;
                end
                p1_x    <= x_c;
                p1_y    <= y_c;
                p1_data <= {r_in, g_in, b_in};
            end else if (start) begin
                col_q   <= '0;
                row_q   <= '0;
                mcu_x_q <= '0;
                mcu_y_q <= '0;
            end

            p1_wr   <= accept && keep;
            p1_last <= accept && last;

            // Anything in stage 1 on a start edge belongs to the aborted frame.
            wr_en      <= p1_wr && !start;
            frame_done <= start ? zero_geom : p1_last;
            if (p1_wr && !start) begin
                wr_addr <= ADDR_W'(p1_y) * ADDR_W'(width_q) + ADDR_W'(p1_x);
                wr_data <= p1_data;
            end

            if (start)
                overrun <= 1'b0;
            else if (pixel_valid && state == IDLE)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_raster_writer.sv
// Directed bench for pixel_raster_writer: frame geometries, cropping, abort,
// reset and overrun, with hand-derived expected addresses, data and timing.
module tb_pixel_raster_writer;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst, start, mode_420, pixel_valid;
    logic [15:0]   img_width, img_height;
    logic [7:0]    r_in, g_in, b_in;
    logic          wr_en, frame_done, busy, overrun;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;

    pixel_raster_writer #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode_420(mode_420),
        .img_width(img_width), .img_height(img_height),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .pixel_valid(pixel_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            wr_cyc[$];
    logic [AW-1:0] wr_a[$];
    logic [23:0]   wr_d[$];
    int            fd_cyc[$];
    int            fd_nwr[$];

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_cyc.push_back(cyc);
            wr_a.push_back(wr_addr);
            wr_d.push_back(wr_data);
        end
        if (frame_done === 1'b1) begin
            fd_cyc.push_back(cyc);
            fd_nwr.push_back(wr_a.size());
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_cyc.delete(); wr_a.delete(); wr_d.delete();
        fd_cyc.delete(); fd_nwr.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic m, input logic [15:0] w, input logic [15:0] h,
                            input logic with_px, input logic [23:0] d, output int cs);
        start = 1'b1; mode_420 = m; img_width = w; img_height = h;
        pixel_valid = with_px; {r_in, g_in, b_in} = d;
        cs = cyc;
        @(posedge clk); #1;
        start = 1'b0; pixel_valid = 1'b0;
    endtask

    task automatic px(input logic [23:0] d);
        pixel_valid = 1'b1; {r_in, g_in, b_in} = d;
        @(posedge clk); #1;
        pixel_valid = 1'b0;
    endtask

    function automatic logic [23:0] data_at(input logic [AW-1:0] a);
        data_at = 24'hFFFFFF;
        foreach (wr_a[k]) if (wr_a[k] == a) data_at = wr_d[k];
    endfunction

    bit seen [0:359];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cs, cs2, bad, n_old, n_old_late;
        int new_idx [$];

        rst = 1'b1; start = 1'b0; mode_420 = 1'b0; pixel_valid = 1'b0;
        img_width = '0; img_height = '0; {r_in, g_in, b_in} = '0;
        idle(3);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        idle(2);
        clear_log();

        // 8x8 frame, one MCU, data = index
        do_start(1'b0, 16'd8, 16'd8, 1'b0, 24'd0, cs);
        check("t1_busy_after_start", busy, 1);
        for (int i = 0; i < 64; i++) px(24'(i));
        @(negedge clk); @(negedge clk);
        check("t1_fd_now", frame_done, 1);
        check("t1_busy_fd_cycle", busy, 1);
        @(negedge clk);
        check("t1_busy_after_fd", busy, 0);
        check("t1_fd_single_pulse", frame_done, 0);
        @(posedge clk); #1;
        check("t1_nwr", wr_a.size(), 64);
        for (int i = 0; i < 64 && i < wr_a.size(); i++) begin
            check("t1_addr", wr_a[i], i);
            check("t1_data", wr_d[i], i);
            check("t1_cyc", wr_cyc[i], cs + 3 + i);
        end
        check("t1_nfd", fd_cyc.size(), 1);
        if (fd_cyc.size() > 0) begin
            check("t1_fd_cyc", fd_cyc[0], cs + 66);
            check("t1_fd_nwr", fd_nwr[0], 64);
        end
        clear_log();

        // 4:2:0, 20x18: 2x2 MCUs, 1024 pixels, 360 kept
        do_start(1'b1, 16'd20, 16'd18, 1'b0, 24'd0, cs);
        for (int i = 0; i < 1024; i++) px({8'd0, 16'(i)});
        idle(4);
        check("t2_nwr", wr_a.size(), 360);
        bad = 0;
        foreach (seen[k]) seen[k] = 1'b0;
        foreach (wr_a[k]) begin
            if (wr_a[k] >= 360 || seen[wr_a[k]]) bad++;
            else seen[wr_a[k]] = 1'b1;
        end
        check("t2_addr_set", bad, 0);
        check("t2_addr359", data_at(359), 24'h000313);
        check("t2_addr0", data_at(0), 24'h000000);
        check("t2_addr20", data_at(20), 24'h000010);
        check("t2_addr16", data_at(16), 24'h000100);
        check("t2_nfd", fd_cyc.size(), 1);
        if (fd_cyc.size() > 0) begin
            check("t2_fd_cyc", fd_cyc[0], cs + 1026);
            check("t2_fd_nwr", fd_nwr[0], 360);
        end
        clear_log();

        // 8x8, 9x1 image: 2 MCUs, start shares its cycle with pixel 0
        do_start(1'b0, 16'd9, 16'd1, 1'b1, 24'd0, cs);
        for (int i = 1; i < 128; i++) px(24'(i));
        idle(4);
        check("t3_nwr", wr_a.size(), 9);
        for (int i = 0; i < 8 && i < wr_a.size(); i++) begin
            check("t3_addr", wr_a[i], i);
            check("t3_data", wr_d[i], i);
        end
        if (wr_a.size() > 8) begin
            check("t3_addr8", wr_a[8], 8);
            check("t3_data8", wr_d[8], 64);
            check("t3_cyc8", wr_cyc[8], cs + 66);
        end
        if (wr_a.size() > 0) check("t3_first_cyc", wr_cyc[0], cs + 2);
        check("t3_nfd", fd_cyc.size(), 1);
        if (fd_cyc.size() > 0) check("t3_fd_cyc", fd_cyc[0], cs + 129);
        clear_log();

        // zero width: immediate frame_done, never busy
        do_start(1'b0, 16'd0, 16'd8, 1'b0, 24'd0, cs);
        check("t4_busy", busy, 0);
        @(negedge clk);
        check("t4_fd_now", frame_done, 1);
        @(posedge clk); #1;
        idle(3);
        check("t4_busy_later", busy, 0);
        check("t4_nwr", wr_a.size(), 0);
        check("t4_nfd", fd_cyc.size(), 1);
        if (fd_cyc.size() > 0) check("t4_fd_cyc", fd_cyc[0], cs + 1);
        clear_log();

        // overrun: pixel while idle
        px(24'h123456);
        idle(3);
        check("t5_overrun_set", overrun, 1);
        check("t5_overrun_nwr", wr_a.size(), 0);
        idle(3);
        check("t5_overrun_sticky", overrun, 1);
        clear_log();

        // abort: 10 pixels of an 8x8 frame, then restart 8x8
        do_start(1'b0, 16'd8, 16'd8, 1'b0, 24'd0, cs);
        check("t5_overrun_cleared", overrun, 0);
        for (int i = 0; i < 10; i++) px(24'(i));
        do_start(1'b0, 16'd8, 16'd8, 1'b0, 24'd0, cs2);
        for (int i = 0; i < 64; i++) px(24'h800000 | 24'(i));
        idle(5);
        n_old = 0; n_old_late = 0;
        new_idx.delete();
        foreach (wr_d[k]) begin
            if (wr_d[k][23] == 1'b0) begin
                n_old++;
                if (wr_cyc[k] > cs2) n_old_late++;
            end else begin
                new_idx.push_back(k);
            end
        end
        check("t6_old_writes", n_old, 9);
        check("t6_old_late", n_old_late, 0);
        check("t6_new_writes", new_idx.size(), 64);
        for (int i = 0; i < 64 && i < new_idx.size(); i++) begin
            check("t6_addr", wr_a[new_idx[i]], i);
            check("t6_data", wr_d[new_idx[i]], 24'h800000 | 24'(i));
        end
        check("t6_nfd", fd_cyc.size(), 1);
        if (fd_cyc.size() > 0) check("t6_fd_cyc", fd_cyc[0], cs2 + 66);
        clear_log();

        // reset mid-frame
        do_start(1'b0, 16'd8, 16'd8, 1'b0, 24'd0, cs);
        for (int i = 0; i < 20; i++) px(24'h00AA00 | 24'(i));
        rst = 1'b1; pixel_valid = 1'b1; {r_in, g_in, b_in} = 24'h00AA14;
        @(posedge clk); #1;
        rst = 1'b0; pixel_valid = 1'b0;
        check("t7_wr_en", wr_en, 0);
        check("t7_wr_addr", wr_addr, 0);
        check("t7_wr_data", wr_data, 0);
        check("t7_frame_done", frame_done, 0);
        check("t7_busy", busy, 0);
        check("t7_overrun", overrun, 0);
        clear_log();
        idle(10);
        check("t7_nwr_after", wr_a.size(), 0);
        check("t7_nfd_after", fd_cyc.size(), 0);
        check("t7_busy_after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
